// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, branch redirect and halt detection.
// state | meaning
// RUN   | fetching sequentially, honouring stalls and branch redirects
// HALT  | halt word captured; fetch frozen until reset
module fetch_unit #(
    parameter logic [18:0] RESET_PC  = 19'h00000,
    parameter logic [18:0] HALT_WORD = 19'h7FFFF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [18:0] pc,
    input  logic [18:0] RD,
    input  logic        branch_en,
    input  logic [18:0] branch_target,
    input  logic        id_ready,
    output logic [18:0] instr_out,
    output logic [18:0] pc_out,
    output logic        instr_valid,
    output logic        halted
);

    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    localparam logic [18:0] WORD_MASK = 19'h7FFFC;

    state_t      state_q, state_d;
    logic [18:0] pc_q, pc_d;
    logic [18:0] instr_q, instr_d;
    logic [18:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC & WORD_MASK;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        case (state_q)
            RUN: begin
                if (branch_en) begin
                    pc_d    = branch_target & WORD_MASK;
                    valid_d = 1'b0;
                end else if (!valid_q || id_ready) begin
                    instr_d  = RD;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    // The halt word parks pc on its own address.
                    if (RD == HALT_WORD) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 19'd4;
                    end
                end
            end
            HALT: begin
                if (valid_q && id_ready) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign pc          = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign halted      = (state_q == HALT);

endmodule
